// File: rtl/dpram_pkg.sv
// Shared definitions for the dual-port RAM with zero-initialisation engine:
// FSM state encoding, byte-lane helpers and the per-byte even-parity function.
package dpram_pkg;

    typedef enum logic [1:0] {
        S_RESET = 2'd0,
        S_INIT  = 2'd1,
        S_READY = 2'd2
    } state_t;

    localparam int BYTE_W     = 8;
    localparam int MAX_DATA_W = 256;
    localparam int MAX_LANES  = MAX_DATA_W / BYTE_W;

    // Number of byte lanes in a word of the given width.
    function automatic int byte_lanes(input int data_w);
        return data_w / BYTE_W;
    endfunction

    // Even parity per byte lane; callers zero-extend narrower words, so the
    // unused upper lanes come back as 0.
    function automatic logic [MAX_LANES-1:0] byte_parity(input logic [MAX_DATA_W-1:0] data);
        logic [MAX_LANES-1:0] par;
        for (int i = 0; i < MAX_LANES; i++) begin
            par[i] = ^data[BYTE_W*i +: BYTE_W];
        end
        return par;
    endfunction

endpackage

// File: rtl/dpram_init_fsm.sv
// Reset / clear sequencer for dpram_sync_init. After reset release it walks a
// counter across the whole array, issuing one zero-write per cycle, then
// reports ready. init_busy is high from reset until the last clear write.
module dpram_init_fsm
    import dpram_pkg::*;
#(
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst,
    output logic              init_busy,
    output logic              ready,
    output logic              clr_we,
    output logic [ADDR_W-1:0] clr_addr
);

    state_t            state;
    state_t            state_next;
    logic [ADDR_W-1:0] count;

    // State register and clear counter; counter only advances while clearing.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= S_RESET;
            count <= '0;
        end else begin
            state <= state_next;
            if (state == S_INIT) begin
                count <= count + ADDR_W'(1);
            end
        end
    end

    // Next-state decode and clear-write strobe; the strobe is suppressed
    // whenever rst is low so no write lands in a reset cycle.
    always_comb begin
        state_next = state;
        init_busy  = 1'b1;
        ready      = 1'b0;
        clr_we     = 1'b0;
        case (state)
            S_RESET: begin
                state_next = S_INIT;
            end
            S_INIT: begin
                clr_we = rst;
                if (&count) begin
                    state_next = S_READY;
                end
            end
            S_READY: begin
                init_busy = 1'b0;
                ready     = 1'b1;
            end
            default: begin
                state_next = S_RESET;
            end
        endcase
    end

    assign clr_addr = count;

endmodule

// File: rtl/dpram_sync_init.sv
// Parametrised simple dual-port synchronous RAM (one write port, one read
// port, shared clock) with byte enables, write-first collision merge, a
// read-valid strobe, 1- or 2-cycle read latency and a sequential zero clear
// after reset. Optional per-byte even parity is enabled by defining
// DPRAM_PARITY_EN; without it par_err is tied low.
module dpram_sync_init
    import dpram_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 6,
    parameter int RD_LAT = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable,
    input  logic                wr,
    input  logic [ADDR_W-1:0]   wr_addr,
    input  logic [DATA_W-1:0]   wr_data,
    input  logic [DATA_W/8-1:0] wr_be,
    input  logic                rd,
    input  logic [ADDR_W-1:0]   rd_addr,
    output logic [DATA_W-1:0]   rd_data,
    output logic                rd_valid,
    output logic                init_busy,
    output logic                par_err
);

    localparam int LANES = byte_lanes(DATA_W);
    localparam int DEPTH = 2 ** ADDR_W;

    logic              ready;
    logic              clr_we;
    logic [ADDR_W-1:0] clr_addr;

    dpram_init_fsm #(
        .ADDR_W (ADDR_W)
    ) u_init_fsm (
        .clk       (clk),
        .rst       (rst),
        .init_busy (init_busy),
        .ready     (ready),
        .clr_we    (clr_we),
        .clr_addr  (clr_addr)
    );

    // User requests only count once the clear has finished and rst is high.
    logic wr_acc;
    logic rd_acc;
    logic collide;

    assign wr_acc  = ready & rst & enable & wr;
    assign rd_acc  = ready & rst & enable & rd;
    assign collide = wr_acc && (wr_addr == rd_addr);

    logic [DATA_W-1:0] mem [DEPTH];

    // Array write port: clear engine during init, byte-masked user writes after.
    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem[clr_addr] <= '0;
        end else if (wr_acc) begin
            for (int i = 0; i < LANES; i++) begin
                if (wr_be[i]) begin
                    mem[wr_addr][BYTE_W*i +: BYTE_W] <= wr_data[BYTE_W*i +: BYTE_W];
                end
            end
        end
    end

    // Read word with write-first merge of the enabled bytes on an address match.
    logic [DATA_W-1:0] rd_word;
    always_comb begin
        rd_word = mem[rd_addr];
        if (collide) begin
            for (int i = 0; i < LANES; i++) begin
                if (wr_be[i]) begin
                    rd_word[BYTE_W*i +: BYTE_W] = wr_data[BYTE_W*i +: BYTE_W];
                end
            end
        end
    end

    logic [DATA_W-1:0] rd_data_p0;
    logic              vld_p0;

    // Stage 0: capture the read word; data holds between accepted reads.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rd_data_p0 <= '0;
            vld_p0     <= 1'b0;
        end else begin
            vld_p0 <= rd_acc;
            if (rd_acc) begin
                rd_data_p0 <= rd_word;
            end
        end
    end

    generate
        if (RD_LAT == 2) begin : g_lat2
            logic [DATA_W-1:0] rd_data_p1;
            logic              vld_p1;

            // Stage 1: output register; in-flight reads finish regardless of enable.
            always_ff @(posedge clk) begin
                if (!rst) begin
                    rd_data_p1 <= '0;
                    vld_p1     <= 1'b0;
                end else begin
                    vld_p1 <= vld_p0;
                    if (vld_p0) begin
                        rd_data_p1 <= rd_data_p0;
                    end
                end
            end

            assign rd_data  = rd_data_p1;
            assign rd_valid = vld_p1;
        end else begin : g_lat1
            assign rd_data  = rd_data_p0;
            assign rd_valid = vld_p0;
        end
    endgenerate

`ifdef DPRAM_PARITY_EN
    logic [LANES-1:0]      mem_par [DEPTH];
    logic [LANES-1:0]      wr_par;
    logic [LANES-1:0]      rd_par_word;
    logic [LANES-1:0]      rd_par_p0;
    logic [LANES-1:0]      rd_par_out;
    logic [MAX_DATA_W-1:0] wr_ext;
    logic [MAX_DATA_W-1:0] out_ext;
    logic [MAX_LANES-1:0]  wr_par_full;
    logic [MAX_LANES-1:0]  out_par_full;

    // Parity of the incoming write data, one bit per byte lane.
    always_comb begin
        wr_ext              = '0;
        wr_ext[DATA_W-1:0]  = wr_data;
        wr_par_full         = byte_parity(wr_ext);
        wr_par              = wr_par_full[LANES-1:0];
    end

    // Parity array write port, lane-aligned with the data array (0 is even parity of 0).
    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem_par[clr_addr] <= '0;
        end else if (wr_acc) begin
            for (int i = 0; i < LANES; i++) begin
                if (wr_be[i]) begin
                    mem_par[wr_addr][i] <= wr_par[i];
                end
            end
        end
    end

    // Stored parity with collision-merged lanes taking the write-data parity.
    always_comb begin
        rd_par_word = mem_par[rd_addr];
        if (collide) begin
            for (int i = 0; i < LANES; i++) begin
                if (wr_be[i]) begin
                    rd_par_word[i] = wr_par[i];
                end
            end
        end
    end

    // Stage 0 parity capture, travelling with rd_data_p0.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rd_par_p0 <= '0;
        end else if (rd_acc) begin
            rd_par_p0 <= rd_par_word;
        end
    end

    generate
        if (RD_LAT == 2) begin : g_par_lat2
            logic [LANES-1:0] rd_par_p1;

            // Stage 1 parity register, travelling with rd_data_p1.
            always_ff @(posedge clk) begin
                if (!rst) begin
                    rd_par_p1 <= '0;
                end else if (vld_p0) begin
                    rd_par_p1 <= rd_par_p0;
                end
            end

            assign rd_par_out = rd_par_p1;
        end else begin : g_par_lat1
            assign rd_par_out = rd_par_p0;
        end
    endgenerate

    // Recompute parity over the presented data and flag any lane mismatch.
    always_comb begin
        out_ext             = '0;
        out_ext[DATA_W-1:0] = rd_data;
        out_par_full        = byte_parity(out_ext);
        par_err             = rd_valid && (out_par_full[LANES-1:0] != rd_par_out);
    end
`else
    assign par_err = 1'b0;
`endif

endmodule

// File: tb/tb_dpram_sync_init.sv
// Directed bench for dpram_sync_init. Two instances share control and
// addresses: dut_a (8-bit, RD_LAT=1) and dut_b (32-bit, RD_LAT=2).
module tb_dpram_sync_init;

    logic        clk;
    logic        rst;
    logic        enable;
    logic        wr;
    logic        rd;
    logic [5:0]  wr_addr;
    logic [5:0]  rd_addr;
    logic [7:0]  wr_data_a;
    logic [0:0]  wr_be_a;
    logic [31:0] wr_data_b;
    logic [3:0]  wr_be_b;
    logic [7:0]  rd_data_a;
    logic        rd_valid_a;
    logic        init_busy_a;
    logic        par_err_a;
    logic [31:0] rd_data_b;
    logic        rd_valid_b;
    logic        init_busy_b;
    logic        par_err_b;

    int checks   = 0;
    int failures = 0;

    dpram_sync_init #(.DATA_W(8), .ADDR_W(6), .RD_LAT(1)) dut_a (
        .clk(clk), .rst(rst), .enable(enable), .wr(wr), .wr_addr(wr_addr),
        .wr_data(wr_data_a), .wr_be(wr_be_a), .rd(rd), .rd_addr(rd_addr),
        .rd_data(rd_data_a), .rd_valid(rd_valid_a), .init_busy(init_busy_a),
        .par_err(par_err_a)
    );

    dpram_sync_init #(.DATA_W(32), .ADDR_W(6), .RD_LAT(2)) dut_b (
        .clk(clk), .rst(rst), .enable(enable), .wr(wr), .wr_addr(wr_addr),
        .wr_data(wr_data_b), .wr_be(wr_be_b), .rd(rd), .rd_addr(rd_addr),
        .rd_data(rd_data_b), .rd_valid(rd_valid_b), .init_busy(init_busy_b),
        .par_err(par_err_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic idle();
        enable = 1'b0; wr = 1'b0; rd = 1'b0;
        wr_addr = '0; rd_addr = '0;
        wr_data_a = '0; wr_be_a = '0; wr_data_b = '0; wr_be_b = '0;
    endtask

    task automatic sample();
        @(posedge clk);
        #1;
    endtask

    // Release rst and count post-edge samples with init_busy high (bounded).
    task automatic run_init(input bit noisy, output int busy_a, output int busy_b, output int vld);
        busy_a = 0; busy_b = 0; vld = 0;
        @(negedge clk);
        rst = 1'b1;
        if (noisy) begin
            enable = 1'b1; wr = 1'b1; rd = 1'b1; wr_addr = 6'h02; rd_addr = 6'h02;
            wr_data_a = 8'hEE; wr_be_a = 1'b1; wr_data_b = 32'hEEEE_EEEE; wr_be_b = 4'hF;
        end
        for (int i = 0; i < 200; i++) begin
            sample();
            if (init_busy_a) busy_a++;
            if (init_busy_b) busy_b++;
            if (rd_valid_a || rd_valid_b) vld++;
            if (!init_busy_a && !init_busy_b) break;
        end
        @(negedge clk);
        idle();
    endtask

    task automatic test_reset();
        rst = 1'b0;
        idle();
        repeat (3) sample();
        checks++; if (rd_valid_a !== 1'b0 || rd_data_a !== 8'h00) begin failures++; $display("FAIL reset_a valid=%b data=%h expected 0/00", rd_valid_a, rd_data_a); end
        checks++; if (rd_valid_b !== 1'b0 || rd_data_b !== 32'h0) begin failures++; $display("FAIL reset_b valid=%b data=%h expected 0/0", rd_valid_b, rd_data_b); end
        checks++; if (init_busy_a !== 1'b1 || init_busy_b !== 1'b1) begin failures++; $display("FAIL reset_busy a=%b b=%b expected 1", init_busy_a, init_busy_b); end
        checks++; if (par_err_a !== 1'b0 || par_err_b !== 1'b0) begin failures++; $display("FAIL reset_par a=%b b=%b expected 0", par_err_a, par_err_b); end
    endtask

    task automatic test_init();
        int ba, bb, v;
        run_init(1'b0, ba, bb, v);
        checks++; if (ba !== 64) begin failures++; $display("FAIL init_len_a got=%0d expected=64", ba); end
        checks++; if (bb !== 64) begin failures++; $display("FAIL init_len_b got=%0d expected=64", bb); end
    endtask

    task automatic test_init_readback();
        int vb = 0;
        int bad_b = 0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            enable = 1'b1; rd = 1'b1; rd_addr = 6'(i);
            sample();
            checks++; if (rd_valid_a !== 1'b1 || rd_data_a !== 8'h00) begin failures++; $display("FAIL readback_a addr=%0d valid=%b data=%h expected 1/00", i, rd_valid_a, rd_data_a); end
            if (rd_valid_b) begin vb++; if (rd_data_b !== 32'h0) bad_b++; end
        end
        @(negedge clk);
        rd = 1'b0;
        sample();
        if (rd_valid_b) begin vb++; if (rd_data_b !== 32'h0) bad_b++; end
        checks++; if (rd_valid_a !== 1'b0) begin failures++; $display("FAIL readback_a_end valid=%b expected 0", rd_valid_a); end
        sample();
        checks++; if (rd_valid_b !== 1'b0) begin failures++; $display("FAIL readback_b_end valid=%b expected 0", rd_valid_b); end
        checks++; if (vb !== 64 || bad_b !== 0) begin failures++; $display("FAIL readback_b pulses=%0d nonzero=%0d expected 64/0", vb, bad_b); end
    endtask

    task automatic test_write_read();
        @(negedge clk);
        enable = 1'b1; wr = 1'b1; wr_addr = 6'h10;
        wr_data_a = 8'hA5; wr_be_a = 1'b1; wr_data_b = 32'hCAFE_F00D; wr_be_b = 4'hF;
        sample();
        @(negedge clk);
        wr = 1'b0; rd = 1'b1; rd_addr = 6'h10;
        sample();
        checks++; if (rd_valid_a !== 1'b1 || rd_data_a !== 8'hA5) begin failures++; $display("FAIL wr_rd_a valid=%b data=%h expected 1/a5", rd_valid_a, rd_data_a); end
        checks++; if (rd_valid_b !== 1'b0) begin failures++; $display("FAIL wr_rd_b_early valid=%b expected 0", rd_valid_b); end
        @(negedge clk);
        rd = 1'b0;
        sample();
        checks++; if (rd_valid_a !== 1'b0 || rd_data_a !== 8'hA5) begin failures++; $display("FAIL wr_rd_a_hold valid=%b data=%h expected 0/a5", rd_valid_a, rd_data_a); end
        checks++; if (rd_valid_b !== 1'b1 || rd_data_b !== 32'hCAFE_F00D) begin failures++; $display("FAIL wr_rd_b valid=%b data=%h expected 1/cafef00d", rd_valid_b, rd_data_b); end
        sample();
        checks++; if (rd_valid_b !== 1'b0 || rd_data_b !== 32'hCAFE_F00D) begin failures++; $display("FAIL wr_rd_b_hold valid=%b data=%h expected 0/cafef00d", rd_valid_b, rd_data_b); end
    endtask

    task automatic test_byte_enable();
        @(negedge clk);
        enable = 1'b1; wr = 1'b1; wr_addr = 6'h03;
        wr_data_a = 8'h3C; wr_be_a = 1'b1; wr_data_b = 32'h1122_3344; wr_be_b = 4'hF;
        sample();
        @(negedge clk);
        wr_data_a = 8'hFF; wr_be_a = 1'b0; wr_data_b = 32'hAABB_CCDD; wr_be_b = 4'b0101;
        sample();
        @(negedge clk);
        wr = 1'b0; rd = 1'b1; rd_addr = 6'h03;
        sample();
        checks++; if (rd_valid_a !== 1'b1 || rd_data_a !== 8'h3C) begin failures++; $display("FAIL be_a valid=%b data=%h expected 1/3c", rd_valid_a, rd_data_a); end
        @(negedge clk);
        rd = 1'b0;
        sample();
        checks++; if (rd_valid_b !== 1'b1 || rd_data_b !== 32'h11BB_33DD) begin failures++; $display("FAIL be_b valid=%b data=%h expected 1/11bb33dd", rd_valid_b, rd_data_b); end
    endtask

    task automatic test_collision();
        @(negedge clk);
        enable = 1'b1; wr = 1'b1; rd = 1'b1; wr_addr = 6'h07; rd_addr = 6'h07;
        wr_data_a = 8'h5A; wr_be_a = 1'b1; wr_data_b = 32'h5A5A_5A5A; wr_be_b = 4'b0011;
        sample();
        checks++; if (rd_valid_a !== 1'b1 || rd_data_a !== 8'h5A) begin failures++; $display("FAIL coll_a valid=%b data=%h expected 1/5a", rd_valid_a, rd_data_a); end
        @(negedge clk);
        wr_addr = 6'h08; rd_addr = 6'h08;
        wr_data_a = 8'hFF; wr_be_a = 1'b0; wr_data_b = 32'hFFFF_FFFF; wr_be_b = 4'b0000;
        sample();
        checks++; if (rd_valid_a !== 1'b1 || rd_data_a !== 8'h00) begin failures++; $display("FAIL coll_be0_a valid=%b data=%h expected 1/00", rd_valid_a, rd_data_a); end
        checks++; if (rd_valid_b !== 1'b1 || rd_data_b !== 32'h0000_5A5A) begin failures++; $display("FAIL coll_b valid=%b data=%h expected 1/00005a5a", rd_valid_b, rd_data_b); end
        @(negedge clk);
        wr = 1'b0; rd_addr = 6'h07;
        sample();
        checks++; if (rd_valid_a !== 1'b1 || rd_data_a !== 8'h5A) begin failures++; $display("FAIL coll_stored_a valid=%b data=%h expected 1/5a", rd_valid_a, rd_data_a); end
        checks++; if (rd_valid_b !== 1'b1 || rd_data_b !== 32'h0) begin failures++; $display("FAIL coll_be0_b valid=%b data=%h expected 1/0", rd_valid_b, rd_data_b); end
        @(negedge clk);
        rd = 1'b0;
        sample();
        checks++; if (rd_valid_b !== 1'b1 || rd_data_b !== 32'h0000_5A5A) begin failures++; $display("FAIL coll_stored_b valid=%b data=%h expected 1/00005a5a", rd_valid_b, rd_data_b); end
    endtask

    task automatic test_enable();
        @(negedge clk);
        enable = 1'b1; wr = 1'b0; rd = 1'b1; rd_addr = 6'h10;
        sample();
        checks++; if (rd_valid_a !== 1'b1 || rd_data_a !== 8'hA5) begin failures++; $display("FAIL en_a valid=%b data=%h expected 1/a5", rd_valid_a, rd_data_a); end
        @(negedge clk);
        enable = 1'b0; wr = 1'b1; rd = 1'b1; wr_addr = 6'h20; rd_addr = 6'h20;
        wr_data_a = 8'h77; wr_be_a = 1'b1; wr_data_b = 32'h7777_7777; wr_be_b = 4'hF;
        sample();
        checks++; if (rd_valid_a !== 1'b0 || rd_data_a !== 8'hA5) begin failures++; $display("FAIL en_off_a valid=%b data=%h expected 0/a5", rd_valid_a, rd_data_a); end
        checks++; if (rd_valid_b !== 1'b1 || rd_data_b !== 32'hCAFE_F00D) begin failures++; $display("FAIL en_inflight_b valid=%b data=%h expected 1/cafef00d", rd_valid_b, rd_data_b); end
        @(negedge clk);
        enable = 1'b1; wr = 1'b0;
        sample();
        checks++; if (rd_valid_a !== 1'b1 || rd_data_a !== 8'h00) begin failures++; $display("FAIL en_nowrite_a valid=%b data=%h expected 1/00", rd_valid_a, rd_data_a); end
        checks++; if (rd_valid_b !== 1'b0) begin failures++; $display("FAIL en_off_b valid=%b expected 0", rd_valid_b); end
        @(negedge clk);
        rd = 1'b0;
        sample();
        checks++; if (rd_valid_b !== 1'b1 || rd_data_b !== 32'h0) begin failures++; $display("FAIL en_nowrite_b valid=%b data=%h expected 1/0", rd_valid_b, rd_data_b); end
    endtask

    task automatic test_back_to_back();
        logic [7:0]  va [4] = '{8'h12, 8'h34, 8'h56, 8'h78};
        logic [31:0] vb [4] = '{32'h0102_0304, 32'h0506_0708, 32'h090A_0B0C, 32'h0D0E_0F10};
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            enable = 1'b1; wr = 1'b1; wr_addr = 6'(6'h30 + i);
            wr_data_a = va[i]; wr_be_a = 1'b1; wr_data_b = vb[i]; wr_be_b = 4'hF;
            sample();
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            wr = 1'b0;
            rd = (i < 4);
            rd_addr = 6'(6'h30 + i);
            sample();
            if (i < 4) begin
                checks++; if (rd_valid_a !== 1'b1 || rd_data_a !== va[i]) begin failures++; $display("FAIL b2b_a idx=%0d valid=%b data=%h expected 1/%h", i, rd_valid_a, rd_data_a, va[i]); end
            end
            if (i > 0) begin
                checks++; if (rd_valid_b !== 1'b1 || rd_data_b !== vb[i-1]) begin failures++; $display("FAIL b2b_b idx=%0d valid=%b data=%h expected 1/%h", i - 1, rd_valid_b, rd_data_b, vb[i-1]); end
            end
        end
        @(negedge clk);
        idle();
    endtask

    task automatic test_reset_mid_init();
        int ba, bb, v;
        int v_first = 0;
        @(negedge clk);
        rst = 1'b0;
        repeat (2) sample();
        checks++; if (rd_data_a !== 8'h00 || rd_data_b !== 32'h0 || init_busy_a !== 1'b1) begin failures++; $display("FAIL rerst data_a=%h data_b=%h busy=%b expected 00/0/1", rd_data_a, rd_data_b, init_busy_a); end
        @(negedge clk);
        rst = 1'b1;
        enable = 1'b1; wr = 1'b1; rd = 1'b1; wr_addr = 6'h02; rd_addr = 6'h02;
        wr_data_a = 8'hEE; wr_be_a = 1'b1; wr_data_b = 32'hEEEE_EEEE; wr_be_b = 4'hF;
        repeat (20) begin
            sample();
            if (rd_valid_a || rd_valid_b) v_first++;
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (2) sample();
        run_init(1'b1, ba, bb, v);
        checks++; if (ba !== 64 || bb !== 64) begin failures++; $display("FAIL midinit_len a=%0d b=%0d expected 64", ba, bb); end
        checks++; if (v_first + v !== 0) begin failures++; $display("FAIL midinit_valid pulses=%0d expected 0", v_first + v); end
        @(negedge clk);
        enable = 1'b1; rd = 1'b1; rd_addr = 6'h02;
        sample();
        checks++; if (rd_valid_a !== 1'b1 || rd_data_a !== 8'h00) begin failures++; $display("FAIL midinit_mem_a valid=%b data=%h expected 1/00", rd_valid_a, rd_data_a); end
        @(negedge clk);
        rd_addr = 6'h10;
        sample();
        checks++; if (rd_valid_a !== 1'b1 || rd_data_a !== 8'h00) begin failures++; $display("FAIL midinit_clear_a valid=%b data=%h expected 1/00", rd_valid_a, rd_data_a); end
        checks++; if (rd_valid_b !== 1'b1 || rd_data_b !== 32'h0) begin failures++; $display("FAIL midinit_mem_b valid=%b data=%h expected 1/0", rd_valid_b, rd_data_b); end
        @(negedge clk);
        rd = 1'b0;
        sample();
        checks++; if (rd_valid_b !== 1'b1 || rd_data_b !== 32'h0) begin failures++; $display("FAIL midinit_clear_b valid=%b data=%h expected 1/0", rd_valid_b, rd_data_b); end
    endtask

    task automatic test_parity();
        @(negedge clk);
        enable = 1'b1; wr = 1'b1; wr_addr = 6'h05;
        wr_data_a = 8'h0F; wr_be_a = 1'b1; wr_data_b = 32'h0F0F_0F0F; wr_be_b = 4'hF;
        sample();
        @(negedge clk);
        wr = 1'b0; rd = 1'b1; rd_addr = 6'h05;
        sample();
        checks++; if (rd_valid_a !== 1'b1 || par_err_a !== 1'b0) begin failures++; $display("FAIL par_clean_a valid=%b par_err=%b expected 1/0", rd_valid_a, par_err_a); end
`ifdef DPRAM_PARITY_EN
        @(negedge clk);
        rd = 1'b0;
        dut_a.mem[5] = dut_a.mem[5] ^ 8'h01;
        sample();
        @(negedge clk);
        rd = 1'b1; rd_addr = 6'h05;
        sample();
        checks++; if (rd_valid_a !== 1'b1 || rd_data_a !== 8'h0E || par_err_a !== 1'b1) begin failures++; $display("FAIL par_flip_a valid=%b data=%h par_err=%b expected 1/0e/1", rd_valid_a, rd_data_a, par_err_a); end
        @(negedge clk);
        rd_addr = 6'h06;
        sample();
        checks++; if (rd_valid_a !== 1'b1 || par_err_a !== 1'b0) begin failures++; $display("FAIL par_other_a valid=%b par_err=%b expected 1/0", rd_valid_a, par_err_a); end
`else
        @(negedge clk);
        rd_addr = 6'h03;
        sample();
        checks++; if (rd_valid_a !== 1'b1 || par_err_a !== 1'b0) begin failures++; $display("FAIL par_off_a valid=%b par_err=%b expected 1/0", rd_valid_a, par_err_a); end
        checks++; if (rd_valid_b !== 1'b1 || par_err_b !== 1'b0) begin failures++; $display("FAIL par_off_b valid=%b par_err=%b expected 1/0", rd_valid_b, par_err_b); end
`endif
        @(negedge clk);
        rd = 1'b0;
        sample();
        checks++; if (rd_valid_b !== 1'b1 || par_err_b !== 1'b0) begin failures++; $display("FAIL par_last_b valid=%b par_err=%b expected 1/0", rd_valid_b, par_err_b); end
        @(negedge clk);
        idle();
    endtask

    initial begin
        test_reset();
        test_init();
        test_init_readback();
        test_write_read();
        test_byte_enable();
        test_collision();
        test_enable();
        test_back_to_back();
        test_reset_mid_init();
        test_parity();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
